merge_tree_drain: RTL
=====================

// Module: merge_tree_drain
// PURPOSE
//  Downstream drain for the 8-way merge sorting tree. Pops sorted 32-bit keys
//  from the root FIFO (f01 dout/empty/deq) and packs them MSB-first into
//  256-bit lines, matching the tree's input din layout.
//  Detects the end-of-run sentinel, counts keys per run and flags order
//  violations. Presents each line on a valid/ready port to the writer.
// PARAMETERS
//  W         32            key width
//  LANES     8             keys per output line
//  SENTINEL  32'hFFFFFFFF  end-of-run marker key (never counted or packed)
//  CNT_W     16            width of run length counter
// PORTS
//  clk         in   1        single clock, posedge
//  rst         in   1        synchronous, active-high reset
//  tree_dout   in   W        root FIFO head key (valid when !tree_empty)
//  tree_empty  in   1        root FIFO empty
//  tree_deq    out  1        pop root FIFO at this posedge (combinational)
//  out_data    out  W*LANES  packed line; lane i at bits [W*(LANES-i)-1 -: W]
//  out_keep    out  LANES    lane-valid mask; lane i -> bit LANES-1-i
//  out_valid   out  1        line valid
//  out_ready   in   1        consumer accepts line on valid&&ready
//  out_last    out  1        line closes the run
//  run_len     out  CNT_W    keys in last completed run (held until next)
//  run_done    out  1        1-cycle pulse when a last line is accepted
//  order_err   out  1        sticky: a key was smaller than its predecessor
// BEHAVIOUR
//  Reset: all outputs 0; state FILL; lane idx 0; count 0; have_prev 0.
//  Reset mid-operation discards the partial line and count.
//  tree_deq is asserted on the first cycle after reset if the tree is non-empty.
//  FSM is FILL / HOLD.
//  FILL: tree_deq = !tree_empty && !rst; out_valid=0.
//   pop key!=SENTINEL:
//    - write lane idx; set keep bit; idx++.
//    - count++, saturating at 2^CNT_W-1.
//    - if have_prev && key<prev (unsigned) then order_err<=1.
//    - prev<=key; have_prev<=1.
//    - if idx was LANES-1: enter HOLD with out_last=0.
//   pop key==SENTINEL:
//    - fill lanes idx..LANES-1 with SENTINEL, keep bits 0.
//    - out_last=1; enter HOLD.
//    - if idx==0: emit empty line (keep=0, data all SENTINEL).
//  HOLD: out_valid=1; tree_deq=0; data/keep/last stable until accepted.
//   out_ready && out_valid:
//    - back to FILL; idx<=0; keep<=0.
//    - if out_last: run_len<=count; run_done pulses the next cycle; count<=0; have_prev<=0.
//  Throughput: LANES pops + 1 handshake cycle per line. No pop while HOLD.
//  Sentinel with tree_empty=1 is ignored (head not valid). Consecutive
//   sentinels produce consecutive empty last lines, each with run_len=0.
//  order_err is cleared only by rst.
// STRUCTURE
//  Shared header sort_defs.vh: KEY_W, SENTINEL, LANES, FILL/HOLD encodings.
//  Same header is used by InputBuffer/MergeComparator tree code.
//  Single module, no sub-modules; lane write is a decoded per-lane register enable.
// TESTING
//  1 Reset, tree_empty=1 -> tree_deq=0, out_valid=0, run_len=0, order_err=0.
//  2 Keys 1..8 then SENTINEL, out_ready=1:
//    - line 1: data=0x00000001_..._00000008, keep=FF, last=0.
//    - line 2: keep=00, last=1; run_len=8; run_done pulses once.
//  3 Keys 5,6,7, SENTINEL:
//    - data={5,6,7,5xFFFFFFFF}, keep=E0, last=1, run_len=3.
//  4 Full line with out_ready=0 for 10 cycles, tree non-empty:
//    - tree_deq=0 throughout; out_data stable.
//    - accepted on ready rise; pops resume the next cycle.
//  5 Keys 9,3 -> order_err=1 the cycle after 3 pops; stays 1 through the next run.
//  6 rst after 4 keys popped:
//    - out_valid=0, count cleared.
//    - next keys 10..17 give a line starting at lane 0 with 0x0000000A.

Source files
------------

// File: rtl/merge_tree_drain_pkg.sv
// Shared definitions for the merge-tree drain: key/line geometry, sentinel and FSM encodings.
package merge_tree_drain_pkg;

    localparam int unsigned W      = 32;
    localparam int unsigned LANES  = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDX_W  = $clog2(LANES);
    localparam int unsigned LINE_W = W * LANES;

    localparam logic [W-1:0] SENTINEL = 32'hFFFF_FFFF;

    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    typedef logic [W-1:0]      key_t;
    typedef logic [LINE_W-1:0] line_t;

    typedef struct packed {
        line_t            data;
        logic [LANES-1:0] keep;
        logic             last;
    } line_beat_t;

    // Run-length increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/merge_tree_drain_if.sv
// Root-FIFO pop port plus packed-line valid/ready port of the merge-tree drain.
interface merge_tree_drain_if;
    import merge_tree_drain_pkg::*;

    key_t             tree_dout;
    logic             tree_empty;
    logic             tree_deq;
    line_t            out_data;
    logic [LANES-1:0] out_keep;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        input  tree_dout, tree_empty, out_ready,
        output tree_deq, out_data, out_keep, out_valid, out_last
    );

    modport slave (
        output tree_dout, tree_empty, out_ready,
        input  tree_deq, out_data, out_keep, out_valid, out_last
    );

endinterface

// File: rtl/merge_tree_drain.sv
// Drains sorted keys from the merge-tree root FIFO, packs them MSB-first into lines,
// tracks run length at the end-of-run sentinel and flags out-of-order keys.
module merge_tree_drain
    import merge_tree_drain_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    merge_tree_drain_if.master bus,
    output logic [CNT_W-1:0]   run_len,
    output logic               run_done,
    output logic               order_err
);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic             pop;
    logic             pop_key;
    logic             pop_sent;
    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] count;
    key_t             prev;
    logic             have_prev;
    line_beat_t       beat;
    logic [LANES-1:0] lane_we;
    logic [LANES-1:0] lane_fill;

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    // Pop only while filling; a line closes on the last lane or on the sentinel.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        accept    = 1'b0;
        case (state)
            FILL: begin
                pop = !bus.tree_empty && !rst;
                if (pop && (bus.tree_dout == SENTINEL || idx == IDX_W'(LANES - 1)))
                    state_nxt = HOLD;
            end
            HOLD: begin
                accept = bus.out_ready;
                if (accept) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    assign pop_key  = pop && (bus.tree_dout != SENTINEL);
    assign pop_sent = pop && (bus.tree_dout == SENTINEL);

    // Lane i takes the key when it is the current slot, or sentinel padding from idx upward.
    always_comb begin
        lane_we   = '0;
        lane_fill = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_we[i]   = pop_key && (idx == IDX_W'(i));
            lane_fill[i] = pop_sent && (IDX_W'(i) >= idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat      <= '0;
            idx       <= '0;
            count     <= '0;
            prev      <= '0;
            have_prev <= 1'b0;
            run_len   <= '0;
            run_done  <= 1'b0;
            order_err <= 1'b0;
        end else begin
            run_done <= accept && beat.last;

            for (int unsigned i = 0; i < LANES; i++) begin
                if (lane_we[i]) begin
                    beat.data[W*(LANES-i)-1 -: W] <= bus.tree_dout;
                    beat.keep[LANES-1-i]          <= 1'b1;
                end else if (lane_fill[i]) begin
                    beat.data[W*(LANES-i)-1 -: W] <= SENTINEL;
                    beat.keep[LANES-1-i]          <= 1'b0;
                end
            end

            if (pop_key) begin
                idx       <= idx + IDX_W'(1);
                count     <= sat_inc(count);
                prev      <= bus.tree_dout;
                have_prev <= 1'b1;
                if (have_prev && (bus.tree_dout < prev)) order_err <= 1'b1;
            end

            if (pop_sent) beat.last <= 1'b1;

            if (accept) begin
                idx       <= '0;
                beat.keep <= '0;
                beat.last <= 1'b0;
                if (beat.last) begin
                    run_len   <= count;
                    count     <= '0;
                    have_prev <= 1'b0;
                end
            end
        end
    end

    assign bus.tree_deq  = pop;
    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = beat.data;
    assign bus.out_keep  = beat.keep;
    assign bus.out_last  = beat.last;

endmodule
